// File: rtl/half_adder_pkg.sv
// half_adder_pkg: shared sizing constants and the carry popcount helper.
package half_adder_pkg;
  localparam int DEFAULT_WIDTH = 1;
  localparam int MAX_WIDTH = 64;
  localparam int MAX_CNT_W = $clog2(MAX_WIDTH + 1);
  function automatic logic [MAX_CNT_W-1:0] popcount(input logic [MAX_WIDTH-1:0] v);
    logic [MAX_CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < MAX_WIDTH; i++) n = n + MAX_CNT_W'(v[i]);
    return n;
  endfunction
endpackage

// File: rtl/half_adder_cell.sv
// half_adder_cell: combinational 1-bit half-adder lane.
module half_adder_cell (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);
  assign s = a ^ b;
  assign c = a & b;
endmodule

// File: rtl/half_adder.sv
// half_adder: registered lane-parallel half adder behind a valid/ready output stage.
// Define HALF_ADDER_STATS_EN to add the txn_count and carry_txn_count outputs.
module half_adder
  import half_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] Sum,
  output logic [WIDTH-1:0] Carry,
  output logic [CNT_W-1:0] carry_cnt,
  output logic             out_valid,
  input  logic             out_ready
`ifdef HALF_ADDER_STATS_EN
  ,
  output logic [31:0]      txn_count,
  output logic [31:0]      carry_txn_count
`endif
);
  logic [WIDTH-1:0] s, c;
  logic [MAX_WIDTH-1:0] c_ext;
  logic accept;
  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    half_adder_cell u_cell (.a(A[i]), .b(B[i]), .s(s[i]), .c(c[i]));
  end
  assign c_ext = MAX_WIDTH'(c);
  assign in_ready = !out_valid || out_ready;
  assign accept = in_valid && in_ready;
  // Data registers load only on accept so X on idle inputs never reaches them.
  always_ff @(posedge clk) begin
    if (rst) begin
      Sum <= '0;
      Carry <= '0;
      carry_cnt <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= accept || (out_valid && !out_ready);
      if (accept) begin
        Sum <= s;
        Carry <= c;
        carry_cnt <= CNT_W'(popcount(c_ext));
      end
    end
  end
`ifdef HALF_ADDER_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      txn_count <= '0;
      carry_txn_count <= '0;
    end else if (accept) begin
      txn_count <= txn_count + 32'd1;
      carry_txn_count <= carry_txn_count + 32'(|c);
    end
  end
`endif
endmodule

// File: tb/tb_half_adder.sv
// tb_half_adder: scoreboard bench driving a WIDTH=1 and a WIDTH=8 instance in lockstep.
module tb_half_adder;
  typedef struct packed {
    logic       s1;
    logic       c1;
    logic       n1;
    logic [7:0] s8;
    logic [7:0] c8;
    logic [3:0] n8;
  } res_t;
  logic clk = 1'b0;
  logic rst, iv, ordy;
  logic [7:0] a8, b8;
  logic ir1, ov1, s1, c1;
  logic [0:0] n1;
  logic ir8, ov8;
  logic [7:0] s8, c8;
  logic [3:0] n8;
  res_t q[$];
  res_t cur;
  logic mv, rdy_exp, rdy1_obs, rdy8_obs;
  int total = 0;
  int bad = 0;
`ifdef HALF_ADDER_STATS_EN
  logic [31:0] tc1, ctc1, tc8, ctc8;
`endif
  always #5 clk = ~clk;
  half_adder #(.WIDTH(1)) u1 (
    .clk(clk), .rst(rst), .A(a8[0]), .B(b8[0]), .in_valid(iv), .in_ready(ir1),
    .Sum(s1), .Carry(c1), .carry_cnt(n1), .out_valid(ov1), .out_ready(ordy)
`ifdef HALF_ADDER_STATS_EN
    , .txn_count(tc1), .carry_txn_count(ctc1)
`endif
  );
  half_adder #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .A(a8), .B(b8), .in_valid(iv), .in_ready(ir8),
    .Sum(s8), .Carry(c8), .carry_cnt(n8), .out_valid(ov8), .out_ready(ordy)
`ifdef HALF_ADDER_STATS_EN
    , .txn_count(tc8), .carry_txn_count(ctc8)
`endif
  );
  task automatic do_reset();
    rst = 1'b1;
    iv = 1'b1;
    ordy = 1'b0;
    a8 = 8'($urandom);
    b8 = 8'($urandom);
    @(posedge clk);
    #1;
    rst = 1'b0;
    mv = 1'b0;
    cur = '0;
    q.delete();
  endtask
  task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b, input logic r);
    logic acc;
    iv = v;
    a8 = a;
    b8 = b;
    ordy = r;
    #1;
    rdy_exp = !mv || r;
    rdy1_obs = ir1;
    rdy8_obs = ir8;
    acc = v && rdy_exp;
    if (acc) q.push_back('{a[0] ^ b[0], a[0] & b[0], a[0] & b[0], a ^ b, a & b, 4'($countones(a & b))});
    @(posedge clk);
    #1;
    mv = acc || (mv && !r);
    if (acc) cur = q.pop_front();
  endtask
  task automatic test_reset();
    do_reset();
    total++; if (ov1 !== 1'b0) begin bad++; $display("FAIL rst_ov1 got=%b want=0", ov1); end
    total++; if (ov8 !== 1'b0) begin bad++; $display("FAIL rst_ov8 got=%b want=0", ov8); end
    total++; if ({s1, c1, n1} !== 3'b000) begin bad++; $display("FAIL rst_regs1 got=%b want=000", {s1, c1, n1}); end
    total++; if (s8 !== 8'h00) begin bad++; $display("FAIL rst_sum8 got=%h want=00", s8); end
    total++; if (c8 !== 8'h00) begin bad++; $display("FAIL rst_carry8 got=%h want=00", c8); end
    total++; if (n8 !== 4'd0) begin bad++; $display("FAIL rst_cnt8 got=%0d want=0", n8); end
    total++; if ({ir1, ir8} !== 2'b11) begin bad++; $display("FAIL rst_ready got=%b want=11", {ir1, ir8}); end
  endtask
  task automatic test_truth_table();
    logic [3:0] ws, wc;
    ws = 4'b0110;
    wc = 4'b1000;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, {8{i[1]}}, {8{i[0]}}, 1'b1);
      total++; if (ov1 !== 1'b1) begin bad++; $display("FAIL tt_ov1[%0d] got=%b want=1", i, ov1); end
      total++; if (s1 !== ws[i]) begin bad++; $display("FAIL tt_sum1[%0d] got=%b want=%b", i, s1, ws[i]); end
      total++; if (c1 !== wc[i]) begin bad++; $display("FAIL tt_carry1[%0d] got=%b want=%b", i, c1, wc[i]); end
      total++; if (n1 !== wc[i]) begin bad++; $display("FAIL tt_cnt1[%0d] got=%b want=%b", i, n1, wc[i]); end
      total++; if (rdy1_obs !== 1'b1) begin bad++; $display("FAIL tt_ready1[%0d] got=%b want=1", i, rdy1_obs); end
    end
  endtask
  task automatic test_wide();
    drive(1'b1, 8'hF0, 8'hCC, 1'b1);
    total++; if (s8 !== 8'h3C) begin bad++; $display("FAIL wide_sum_a got=%h want=3c", s8); end
    total++; if (c8 !== 8'hC0) begin bad++; $display("FAIL wide_carry_a got=%h want=c0", c8); end
    total++; if (n8 !== 4'd2) begin bad++; $display("FAIL wide_cnt_a got=%0d want=2", n8); end
    drive(1'b1, 8'hFF, 8'hFF, 1'b1);
    total++; if (s8 !== 8'h00) begin bad++; $display("FAIL wide_sum_b got=%h want=00", s8); end
    total++; if (c8 !== 8'hFF) begin bad++; $display("FAIL wide_carry_b got=%h want=ff", c8); end
    total++; if (n8 !== 4'd8) begin bad++; $display("FAIL wide_cnt_b got=%0d want=8", n8); end
    total++; if (ov8 !== 1'b1) begin bad++; $display("FAIL wide_ov8 got=%b want=1", ov8); end
  endtask
  task automatic test_backpressure();
    drive(1'b1, 8'hFF, 8'hFF, 1'b1);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 8'h00, 8'hFF, 1'b0);
      total++; if ({rdy1_obs, rdy8_obs} !== 2'b00) begin bad++; $display("FAIL bp_ready[%0d] got=%b want=00", i, {rdy1_obs, rdy8_obs}); end
      total++; if ({ov1, c1, s1} !== 3'b110) begin bad++; $display("FAIL bp_hold1[%0d] got=%b want=110", i, {ov1, c1, s1}); end
      total++; if (c8 !== 8'hFF || n8 !== 4'd8) begin bad++; $display("FAIL bp_hold8[%0d] got=%h/%0d want=ff/8", i, c8, n8); end
    end
    drive(1'b1, 8'h00, 8'hFF, 1'b1);
    total++; if ({ov1, s1, c1} !== 3'b110) begin bad++; $display("FAIL bp_release1 got=%b want=110", {ov1, s1, c1}); end
    total++; if (s8 !== 8'hFF || c8 !== 8'h00) begin bad++; $display("FAIL bp_release8 got=%h/%h want=ff/00", s8, c8); end
  endtask
  task automatic test_reset_stall();
    drive(1'b1, 8'hFF, 8'hFF, 1'b1);
    drive(1'b1, 8'h0F, 8'h0F, 1'b0);
    total++; if ({ov1, ov8} !== 2'b11) begin bad++; $display("FAIL rs_stalled got=%b want=11", {ov1, ov8}); end
    do_reset();
    total++; if ({ov1, ov8} !== 2'b00) begin bad++; $display("FAIL rs_ov got=%b want=00", {ov1, ov8}); end
    total++; if ({s8, c8, n8} !== 20'h0) begin bad++; $display("FAIL rs_regs8 got=%h want=0", {s8, c8, n8}); end
    total++; if ({s1, c1, n1} !== 3'b000) begin bad++; $display("FAIL rs_regs1 got=%b want=000", {s1, c1, n1}); end
    total++; if ({ir1, ir8} !== 2'b11) begin bad++; $display("FAIL rs_ready got=%b want=11", {ir1, ir8}); end
  endtask
  task automatic test_idle();
    drive(1'b1, 8'hFF, 8'h0F, 1'b1);
    drive(1'b0, 8'hxx, 8'hxx, 1'b1);
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, (i == 0) ? 8'hxx : 8'($urandom), (i == 0) ? 8'hxx : 8'($urandom), 1'($urandom));
      total++; if ({ov1, ov8} !== 2'b00) begin bad++; $display("FAIL idle_ov[%0d] got=%b want=00", i, {ov1, ov8}); end
      total++; if (s8 !== 8'hF0 || c8 !== 8'h0F || n8 !== 4'd4) begin bad++; $display("FAIL idle_hold8[%0d] got=%h/%h/%0d want=f0/0f/4", i, s8, c8, n8); end
      total++; if ({s1, c1, n1} !== 3'b011) begin bad++; $display("FAIL idle_hold1[%0d] got=%b want=011", i, {s1, c1, n1}); end
    end
  endtask
  task automatic test_back_to_back();
    for (int i = 0; i < 40; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom), 1'($urandom_range(0, 3) != 0));
      total++; if ({rdy1_obs, rdy8_obs} !== {2{rdy_exp}}) begin bad++; $display("FAIL b2b_ready[%0d] got=%b want=%b", i, {rdy1_obs, rdy8_obs}, {2{rdy_exp}}); end
      total++; if ({ov1, ov8} !== {2{mv}}) begin bad++; $display("FAIL b2b_ov[%0d] got=%b want=%b", i, {ov1, ov8}, {2{mv}}); end
      total++; if ({s8, c8, n8} !== {cur.s8, cur.c8, cur.n8}) begin bad++; $display("FAIL b2b_data8[%0d] got=%h/%h/%0d want=%h/%h/%0d", i, s8, c8, n8, cur.s8, cur.c8, cur.n8); end
      total++; if ({s1, c1, n1} !== {cur.s1, cur.c1, cur.n1}) begin bad++; $display("FAIL b2b_data1[%0d] got=%b want=%b", i, {s1, c1, n1}, {cur.s1, cur.c1, cur.n1}); end
    end
  endtask
  task automatic test_stats();
`ifdef HALF_ADDER_STATS_EN
    do_reset();
    for (int i = 0; i < 4; i++) drive(1'b1, {8{i[1]}}, {8{i[0]}}, 1'b1);
    total++; if (tc1 !== 32'd4 || tc8 !== 32'd4) begin bad++; $display("FAIL stats_txn got=%0d/%0d want=4/4", tc1, tc8); end
    total++; if (ctc1 !== 32'd1 || ctc8 !== 32'd1) begin bad++; $display("FAIL stats_carry got=%0d/%0d want=1/1", ctc1, ctc8); end
    do_reset();
    total++; if ({tc1, ctc1, tc8, ctc8} !== 128'd0) begin bad++; $display("FAIL stats_rst got=%0d/%0d/%0d/%0d want=0", tc1, ctc1, tc8, ctc8); end
`endif
  endtask
  initial begin
    rst = 1'b0;
    iv = 1'b0;
    ordy = 1'b0;
    a8 = '0;
    b8 = '0;
    mv = 1'b0;
    cur = '0;
    test_reset();
    test_truth_table();
    test_wide();
    test_backpressure();
    test_reset_stall();
    test_idle();
    test_back_to_back();
    test_stats();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
